mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register.
- Converts EX/MEM load/store controls into a request/ready transaction on the data-memory port.
- Holds the pipeline (Stall) until memory responds.
- Presents the formatted, sign- or zero-extended load result as Read_Data_Memory to MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting on dmem_ready before abort; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load in MEM stage (from EX/MEM).
- MemWrite  in  1  store in MEM stage (from EX/MEM).
- Funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- Result  in  64  effective byte address (ALU result).
- Write_Data  in  64  store data, right-aligned.
- Read_Data_Memory  out  64  extended load data to MEM/WB.
- Stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM while high.
- Misaligned  out  1  one-cycle pulse on misaligned or illegal access.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  64  doubleword-aligned address (Result with [2:0] = 0).
- dmem_wdata  out  64  lane-shifted store data.
- dmem_wstrb  out  8  byte enables.
- dmem_rdata  in  64  read doubleword.
- dmem_ready  in  1  memory accepts/completes the request this cycle.
- Bus_Error  out  1  timeout pulse; tied 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All outputs 0: Read_Data_Memory, Stall, Misaligned, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, Bus_Error.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access = MemRead | MemWrite.
  - On a legal access: Stall = 1 combinationally; register addr, we, wdata, wstrb, Funct3, Result[2:0]; go to REQ.
  - Otherwise: Stall = 0.
- REQ:
  - dmem_req = 1; Stall = 1.
  - Request fields stay stable until dmem_ready is sampled high.
  - On dmem_ready: for a load, register the formatted rdata into Read_Data_Memory; drop dmem_req next cycle; go to DONE.
- DONE:
  - Stall = 0; access inputs ignored this cycle.
  - The pipeline advances at the end of DONE, so the same instruction is never reissued.
  - Next state: IDLE.
- Latency, access seen in cycle 0:
  - dmem_req is high from cycle 1.
  - With ready in cycle k, DONE is cycle k+1.
  - Zero-wait memory gives 2 stall cycles.
- Read_Data_Memory holds its value until the next completed load; stores do not change it.
- Alignment:
  - Misaligned if (size 2 and addr[0]), (size 4 and addr[1:0] != 0), or (size 8 and addr[2:0] != 0).
  - Funct3 = 111 and MemRead & MemWrite together are illegal.
  - Illegal or misaligned: no request, Misaligned pulse for 1 cycle, Stall = 0, Read_Data_Memory unchanged.
- Store lanes:
  - wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - wdata = Write_Data << (8 * addr[2:0]); bits outside wstrb are don't-care.
- Load format:
  - shifted = dmem_rdata >> (8 * addr[2:0]).
  - Take the low 8/16/32/64 bits.
  - Sign-extend for 000/001/010; zero-extend for 100/101/110.
- Reset asserted in REQ: dmem_req drops immediately; the transaction is abandoned; memory must tolerate a withdrawn request.
- dmem_ready outside REQ is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ready.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, pulse Bus_Error 1 cycle, load Read_Data_Memory = 0 for loads, go to DONE.
- Undefined: no counter; REQ waits indefinitely; Bus_Error is constant 0.

Test Plan:
- LB, Result = 0x1003, dmem_rdata = 0x00000000_80000000, ready in the first REQ cycle -> dmem_addr = 0x1000, Stall high 2 cycles, Read_Data_Memory = 0xFFFFFFFF_FFFFFF80.
- LHU, Result = 0x2006, rdata = 0xBEEF0000_00000000, ready after 3 wait cycles -> dmem_req held 4 cycles with stable fields; Read_Data_Memory = 0x0000_0000_0000_BEEF; Stall low in DONE only.
- SW, Result = 0x3004, Write_Data = 0x12345678 -> dmem_we = 1, dmem_wstrb = 0xF0, dmem_wdata[63:32] = 0x12345678, Read_Data_Memory unchanged.
- LD, Result = 0x4004 -> no dmem_req, Misaligned 1-cycle pulse, Stall = 0; also Funct3 = 111 -> same response.
- Reset asserted mid-REQ -> dmem_req and Stall drop asynchronously, state IDLE; next load completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ready never asserted -> Bus_Error pulse after 4 REQ cycles, Read_Data_Memory = 0, pipeline released.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns EX/MEM load/store controls into a req/ready data-memory transaction.
// Define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES cycles without dmem_ready.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [63:0] Result,
    input  logic [63:0] Write_Data,
    output logic [63:0] Read_Data_Memory,
    output logic        Stall,
    output logic        Misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        Bus_Error
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e     state;
    logic [2:0] funct3_q;
    logic [2:0] offset_q;

    logic       access;
    logic       illegal;
    logic       bad_align;
    logic       legal;
    logic [7:0] size_mask;

    if (TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wait_cnt;
`endif

    // Select the addressed lane, then sign- or zero-extend to 64 bits.
    function automatic logic [63:0] format_load(input logic [63:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [2:0]  off);
        logic [63:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  format_load = {{56{sh[7]}}, sh[7:0]};
            3'b001:  format_load = {{48{sh[15]}}, sh[15:0]};
            3'b010:  format_load = {{32{sh[31]}}, sh[31:0]};
            3'b100:  format_load = {56'd0, sh[7:0]};
            3'b101:  format_load = {48'd0, sh[15:0]};
            3'b110:  format_load = {32'd0, sh[31:0]};
            default: format_load = sh;
        endcase
    endfunction

    always_comb begin
        access    = MemRead | MemWrite;
        size_mask = 8'h01;
        bad_align = 1'b0;
        unique case (Funct3[1:0])
            2'b00: begin
                size_mask = 8'h01;
                bad_align = 1'b0;
            end
            2'b01: begin
                size_mask = 8'h03;
                bad_align = Result[0];
            end
            2'b10: begin
                size_mask = 8'h0F;
                bad_align = |Result[1:0];
            end
            2'b11: begin
                size_mask = 8'hFF;
                bad_align = |Result[2:0];
            end
        endcase
        illegal = (Funct3 == 3'b111) | (MemRead & MemWrite);
        legal   = access & ~illegal & ~bad_align;
    end

    // Stall must rise in the same cycle the access is seen, so it cannot be a register.
    assign Stall = ~reset & (((state == StIdle) & legal) | (state == StReq));

`ifndef MEM_TIMEOUT_EN
    assign Bus_Error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= StIdle;
            funct3_q         <= 3'd0;
            offset_q         <= 3'd0;
            Read_Data_Memory <= 64'd0;
            Misaligned       <= 1'b0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 64'd0;
            dmem_wdata       <= 64'd0;
            dmem_wstrb       <= 8'd0;
`ifdef MEM_TIMEOUT_EN
            Bus_Error        <= 1'b0;
            wait_cnt         <= '0;
`endif
        end else begin
            Misaligned <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            Bus_Error  <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (legal) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite;
                        dmem_addr  <= {Result[63:3], 3'b000};
                        dmem_wdata <= Write_Data << {Result[2:0], 3'b000};
                        dmem_wstrb <= size_mask << Result[2:0];
                        funct3_q   <= Funct3;
                        offset_q   <= Result[2:0];
`ifdef MEM_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                        state      <= StReq;
                    end else if (access) begin
                        Misaligned <= 1'b1;
                    end
                end
                StReq: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            Read_Data_Memory <= format_load(dmem_rdata, funct3_q, offset_q);
                        end
                        state <= StDone;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req  <= 1'b0;
                        Bus_Error <= 1'b1;
                        if (!dmem_we) begin
                            Read_Data_Memory <= 64'd0;
                        end
                        state <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                // Pipeline advances at the end of this cycle; held inputs belong to the
                // instruction just completed.
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
